// File: rtl/rv_fetch_q_if.sv
// Handshake bundle between fetch/I_MEM, the fetch queue and decode.
// The master drives the fetch side and decode ready; the slave is the queue itself.
interface rv_fetch_q_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          imem_vld_Q101H;
    logic [31:0]   imem_instr_Q101H;
    logic [31:0]   pc_Q101H;
    logic          flush_Q102H;
    logic          dec_ready_Q102H;
    logic          instr_vld_Q102H;
    logic [31:0]   instr_Q102H;
    logic [31:0]   pc_Q102H;
    logic          ready_Q100H;
    logic [CW-1:0] count;
    logic          overflow_err;

    modport master (
        output imem_vld_Q101H, imem_instr_Q101H, pc_Q101H, flush_Q102H, dec_ready_Q102H,
        input  instr_vld_Q102H, instr_Q102H, pc_Q102H, ready_Q100H, count, overflow_err
    );

    modport slave (
        input  imem_vld_Q101H, imem_instr_Q101H, pc_Q101H, flush_Q102H, dec_ready_Q102H,
        output instr_vld_Q102H, instr_Q102H, pc_Q102H, ready_Q100H, count, overflow_err
    );
endinterface

// File: rtl/rv_fetch_q.sv
// Instruction fetch queue: buffers {pc, instr} pairs from I_MEM and presents the
// oldest to decode with first-word fall-through; flush discards all entries.
module rv_fetch_q #(
    parameter int DEPTH = 4
) (
    input logic         clk,
    input logic         rst,
    rv_fetch_q_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [63:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic full;
    logic head_vld;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        head_vld = (count_q != '0) && !bus.flush_Q102H;
        pop      = head_vld && bus.dec_ready_Q102H;
        push     = bus.imem_vld_Q101H && !bus.flush_Q102H && (!full || pop);
        drop     = bus.imem_vld_Q101H && !bus.flush_Q102H && full && !pop;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q || drop;
        if (bus.flush_Q102H) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.pc_Q101H, bus.imem_instr_Q101H};
    end

    // Two free slots are needed: one for the word already in flight at Q101H.
    always_comb begin
        bus.instr_vld_Q102H = head_vld;
        bus.instr_Q102H     = head_vld ? mem_q[rd_ptr_q][31:0]  : NOP;
        bus.pc_Q102H        = head_vld ? mem_q[rd_ptr_q][63:32] : 32'h0;
        bus.ready_Q100H     = (count_q <= CW'(DEPTH - 2));
        bus.count           = count_q;
        bus.overflow_err    = ovf_q;
    end
endmodule

// File: tb/tb_rv_fetch_q.sv
// Self-checking bench for rv_fetch_q: directed scenarios plus a random phase,
// with a scoreboard queue modelling the expected FIFO contents.
module tb_rv_fetch_q;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [63:0] sb [$];
    logic        modelOvf;
    logic [31:0] randPc;

    rv_fetch_q_if #(.DEPTH(DEPTH)) bus ();

    rv_fetch_q #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the scoreboard given the inputs this cycle.
    task automatic checkAll(input string tag, input logic flush);
        logic        expVld;
        logic [31:0] expInstr;
        logic [31:0] expPc;
        expVld   = (sb.size() != 0) && !flush;
        expInstr = expVld ? sb[0][31:0]  : NOP;
        expPc    = expVld ? sb[0][63:32] : 32'h0;
        checkOutput({tag, ".vld"},   64'(bus.instr_vld_Q102H), 64'(expVld));
        checkOutput({tag, ".instr"}, 64'(bus.instr_Q102H),     64'(expInstr));
        checkOutput({tag, ".pc"},    64'(bus.pc_Q102H),        64'(expPc));
        checkOutput({tag, ".count"}, 64'(bus.count),           64'(sb.size()));
        checkOutput({tag, ".ready"}, 64'(bus.ready_Q100H),     64'((DEPTH - sb.size()) >= 2));
        checkOutput({tag, ".ovf"},   64'(bus.overflow_err),    64'(modelOvf));
    endtask

    // Drive one cycle of inputs, check the head, then advance the scoreboard.
    task automatic applyStimulus(input string tag, input logic vld, input logic [31:0] pc,
                                 input logic [31:0] instr, input logic flush, input logic rdy);
        logic mVld;
        logic mPop;
        logic mFull;
        @(negedge clk);
        bus.imem_vld_Q101H   = vld;
        bus.pc_Q101H         = pc;
        bus.imem_instr_Q101H = instr;
        bus.flush_Q102H      = flush;
        bus.dec_ready_Q102H  = rdy;
        #1;
        checkAll(tag, flush);
        mVld  = (sb.size() != 0) && !flush;
        mPop  = mVld && rdy;
        mFull = (sb.size() == DEPTH);
        if (flush) begin
            sb.delete();
        end else begin
            if (mPop) void'(sb.pop_front());
            if (vld && (!mFull || mPop)) sb.push_back({pc, instr});
            if (vld && mFull && !mPop) modelOvf = 1'b1;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        sb.delete();
        modelOvf = 1'b0;
        checkAll("reset", 1'b0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [31:0] mkInstr(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0F13;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        modelOvf = 1'b0;
        rst      = 1'b0;
        bus.imem_vld_Q101H   = 1'b0;
        bus.pc_Q101H         = '0;
        bus.imem_instr_Q101H = '0;
        bus.flush_Q102H      = 1'b0;
        bus.dec_ready_Q102H  = 1'b0;

        // Reset values while held, then after release.
        #3;
        checkAll("rst_hold", 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // In-order flow-through with decode always ready.
        applyStimulus("flow0", 1'b1, 32'h0, mkInstr(32'h0), 1'b0, 1'b1);
        applyStimulus("flow1", 1'b1, 32'h4, mkInstr(32'h4), 1'b0, 1'b1);
        applyStimulus("flow2", 1'b1, 32'h8, mkInstr(32'h8), 1'b0, 1'b1);
        applyStimulus("flow3", 1'b0, 32'h0, 32'h0,          1'b0, 1'b1);
        applyStimulus("flow4", 1'b0, 32'h0, 32'h0,          1'b0, 1'b1);

        // Fill with decode stalled; head must stay at 0x100.
        for (int i = 0; i < DEPTH; i++)
            applyStimulus("fill", 1'b1, 32'h100 + 32'(4 * i), mkInstr(32'h100 + 32'(4 * i)), 1'b0, 1'b0);
        applyStimulus("full_hold", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Full queue: simultaneous push and pop, write lands at wrapped pointer.
        applyStimulus("full_pp", 1'b1, 32'h110, mkInstr(32'h110), 1'b0, 1'b1);

        // Full queue, no pop: word dropped and sticky error raised.
        applyStimulus("ovf_push", 1'b1, 32'hDEAD_0000, 32'hDEAD_BEEF, 1'b0, 1'b0);
        applyStimulus("ovf_hold", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Drain: 0x104, 0x108, 0x10C, 0x110 then empty.
        for (int i = 0; i < DEPTH + 1; i++)
            applyStimulus("drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Flush with three entries buffered and a word in flight.
        for (int i = 0; i < 3; i++)
            applyStimulus("pre_flush", 1'b1, 32'h200 + 32'(4 * i), mkInstr(32'h200 + 32'(4 * i)), 1'b0, 1'b0);
        applyStimulus("flush", 1'b1, 32'h300, mkInstr(32'h300), 1'b1, 1'b1);
        applyStimulus("post_flush", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        applyStimulus("post_flush2", 1'b1, 32'h400, mkInstr(32'h400), 1'b0, 1'b0);
        applyStimulus("post_flush3", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Only reset clears the sticky overflow.
        doReset();
        applyStimulus("after_rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Random traffic with a fetch stage that honours ready.
        randPc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            logic v;
            logic f;
            v = ((DEPTH - sb.size()) >= 2) && ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 19) == 0);
            applyStimulus("rand", v, randPc, $urandom, f, 1'($urandom_range(0, 1)));
            if (v) randPc = randPc + 32'h4;
        end
        applyStimulus("rand_ovf", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Asynchronous reset mid-operation empties the queue immediately.
        applyStimulus("mid_a", 1'b1, 32'h500, mkInstr(32'h500), 1'b0, 1'b0);
        applyStimulus("mid_b", 1'b1, 32'h504, mkInstr(32'h504), 1'b0, 1'b0);
        applyStimulus("mid_c", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        sb.delete();
        modelOvf = 1'b0;
        checkAll("mid_rst", 1'b0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus("mid_after", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rv_fetch_q.md
# rv_fetch_q

Instruction fetch queue between the I_MEM read port and the decode stage. It captures each instruction word returned by I_MEM together with its Q101H program counter and holds the pair in a small FIFO. It presents the oldest pair to decode at Q102H with a valid/ready handshake. Fetch is throttled through `ready_Q100H`, and all buffered entries are discarded on a control-flow redirect.

## Interface
Parameters:
- `DEPTH`, 4: number of {pc, instr} entries; power of 2, at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `imem_vld_Q101H`  in  1  I_MEM returns a valid instruction this cycle.
- `imem_instr_Q101H`  in  32  instruction word from I_MEM.
- `pc_Q101H`  in  32  PC of that instruction, from the fetch stage.
- `flush_Q102H`  in  1  redirect (taken branch/jump); discard everything.
- `dec_ready_Q102H`  in  1  decode accepts the head entry this cycle.
- `instr_vld_Q102H`  out  1  head entry valid.
- `instr_Q102H`  out  32  head instruction; `32'h0000_0013` (NOP) when not valid.
- `pc_Q102H`  out  32  head PC; `32'h0` when not valid.
- `ready_Q100H`  out  1  fetch may advance its PC register (feeds fetch `ready_Q100H`/`ready_Q101H`).
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `overflow_err`  out  1  sticky: a push was dropped because the queue was full.

## Operation
- Storage: `DEPTH` entries of {pc[31:0], instr[31:0]}. Write pointer `wr_ptr` and read pointer `rd_ptr` are each $clog2(DEPTH) bits and wrap modulo `DEPTH`. `count` runs 0..DEPTH. Storage contents are not reset.
- Head presentation (first-word fall-through):
  - `instr_vld_Q102H = (count != 0) & !flush_Q102H`.
  - When valid, `instr_Q102H`/`pc_Q102H` = entry[rd_ptr]; otherwise NOP/0.
- Pop: `pop = instr_vld_Q102H & dec_ready_Q102H`. Increment `rd_ptr`.
- Push: `push = imem_vld_Q101H & !flush_Q102H & (count < DEPTH | pop)`. Write entry[wr_ptr] and increment `wr_ptr`.
- Count update: `count` += push − pop. A simultaneous push and pop leaves `count` unchanged, including when the queue is full.
- Dropped push: if `imem_vld_Q101H & !flush_Q102H & count == DEPTH & !pop`, the word is dropped and `overflow_err` is set. It clears only on reset.
- Flush: when `flush_Q102H` = 1, the next edge sets `count`, `wr_ptr` and `rd_ptr` to 0. Push and pop are both suppressed in that cycle, and the Q101H word in flight is discarded.
- Backpressure: `ready_Q100H = (DEPTH - count) >= 2`, combinational from the registered `count`. The second free slot absorbs the fetch already in flight at Q101H, so with a conforming fetch stage `overflow_err` never sets.

## Timing
- Reset (`rst` = 0, asynchronous):
  - `count` = 0, pointers = 0, `overflow_err` = 0.
  - `instr_vld_Q102H` = 0, `instr_Q102H` = NOP, `pc_Q102H` = 0, `ready_Q100H` = 1.
- Reset mid-operation aborts everything immediately; no entry survives.
- Latency: a word pushed at edge N is visible at the head in the cycle after edge N. From an empty queue, that is one cycle from `imem_vld_Q101H` to `instr_vld_Q102H`.
- Throughput: one push and one pop per cycle, sustained.
- Handshake: head data is stable while `instr_vld_Q102H` = 1 and `dec_ready_Q102H` = 0. An entry leaves only on a pop.
- Pointer wrap: entry[DEPTH−1] is followed by entry[0] with no bubble.
- `ready_Q100H` deasserts in the cycle after `count` reaches DEPTH−1. It reasserts in the cycle after `count` falls to DEPTH−2 or below, or after a flush.

## Test plan
- Reset: hold `rst` = 0, then release. All outputs hold their reset values. Push PCs 0x0, 0x4, 0x8 with `dec_ready_Q102H` = 1; they appear in order, each one cycle after its push.
- Fill with stall (DEPTH = 4): `dec_ready_Q102H` = 0, push 4 words (0x100..0x10C).
  - `count` reaches 4.
  - `ready_Q100H` = 0 from the cycle after the third push.
  - The head stays at 0x100.
- Full push+pop: queue full, push 0x110 while popping. `count` stays 4, 0x104 becomes the head, and 0x110 is written at wrapped `wr_ptr` = 0. Drain yields 0x104, 0x108, 0x10C, 0x110.
- Overflow: queue full, no pop, push 0xDEAD_0000. The word is dropped, `overflow_err` = 1 and stays 1 until reset; contents are unchanged.
- Flush: 3 entries buffered, then assert `flush_Q102H` with a simultaneous `imem_vld_Q101H` and `dec_ready_Q102H`.
  - `instr_vld_Q102H` = 0 that cycle; next cycle `count` = 0 and `ready_Q100H` = 1.
  - The in-flight word and the head entry are both discarded.
- Random: random `imem_vld_Q101H`/`dec_ready_Q102H` with the fetch stage obeying `ready_Q100H`, plus occasional flush. Output order matches a reference model, and `overflow_err` stays 0.
